barcode_rx: RTL and testbench

//  Parametrised self-timed serial ID receiver; successor to the fixed 8-bit barcode reader.

---
 rtl/barcode_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_barcode_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/barcode_rx.sv
// ---------------------------------------------------------------------------
// barcode_rx
// Self-timed serial ID receiver. A calibration low pulse sets the bit period.
// After that, each data cell begins with a falling edge. The line is sampled
// "half" cycles after that edge, and ID_W cells are shifted in MSB first.
// An optional prefix on the top PREFIX_W bits is checked at frame end.
//
// Ports
//   clk         in   1     system clock
//   rst_n       in   1     asynchronous active-low reset
//   BC          in   1     asynchronous serial line, idles high
//   clr_ID_vld  in   1     consumer acknowledge, clears ID_vld and ovr
//   ID          out  ID_W  last accepted ID
//   ID_vld      out  1     ID holds an unacknowledged valid frame
//   ovr         out  1     sticky, a new ID arrived while ID_vld was set
//   err         out  1     one-cycle pulse, frame aborted
//   err_code    out  2     cause of last err: 01 prefix, 10 timeout,
//                          11 counter saturation
//   busy        out  1     receiver is inside a frame
// ---------------------------------------------------------------------------
module barcode_rx #(
    parameter int                ID_W     = 8,
    parameter int                PREFIX_W = 2,
    parameter int unsigned       PREFIX   = 0,
    parameter int                CNT_W    = 22,
    parameter logic [CNT_W-1:0]  MIN_HALF = 16,
    parameter logic [CNT_W-1:0]  TIMEOUT  = {CNT_W{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BC,
    input  logic            clr_ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            ID_vld,
    output logic            ovr,
    output logic            err,
    output logic [1:0]      err_code,
    output logic            busy
);

    localparam int               BW       = $clog2(ID_W + 1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(ID_W - 1);
    localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAL       = 2'd1,
        ST_WAIT_FALL = 2'd2,
        ST_SAMPLE    = 2'd3
    } state_t;

    state_t            state_r;
    logic              bc_meta_r;
    logic              bc_sync_r;
    logic              bc_dly_r;
    logic              fall_s;
    logic              accept_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  half_r;
    logic [BW-1:0]     bit_cnt_r;
    logic [ID_W-1:0]   shreg_r;
    logic              frame_end_r;
    logic [ID_W-1:0]   id_r;
    logic              id_vld_r;
    logic              ovr_r;
    logic              err_r;
    logic [1:0]        err_code_r;
    logic              busy_r;

    // Returns 1 when the top PREFIX_W bits equal PREFIX. A PREFIX_W of 0
    // disables the check. A shift is used instead of a part-select so that
    // PREFIX_W = 0 stays legal.
    function automatic logic prefix_ok(input logic [ID_W-1:0] v);
        logic [ID_W-1:0] top;
        logic [ID_W-1:0] want;
        top  = v >> (ID_W - PREFIX_W);
        want = ID_W'(PREFIX);
        if (PREFIX_W == 0) begin
            prefix_ok = 1'b1;
        end else begin
            prefix_ok = (top == want);
        end
    endfunction

    assign fall_s   = bc_dly_r & ~bc_sync_r;
    assign accept_s = prefix_ok(shreg_r);

    // Two-flop synchroniser plus one delay stage for edge detection.
    // All stages reset high so that no fall is seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_meta_r <= 1'b1;
            bc_sync_r <= 1'b1;
            bc_dly_r  <= 1'b1;
        end else begin
            bc_meta_r <= BC;
            bc_sync_r <= bc_meta_r;
            bc_dly_r  <= bc_sync_r;
        end
    end

    // Receiver FSM, consumer handshake and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            half_r      <= {CNT_W{1'b0}};
            bit_cnt_r   <= {BW{1'b0}};
            shreg_r     <= {ID_W{1'b0}};
            frame_end_r <= 1'b0;
            id_r        <= {ID_W{1'b0}};
            id_vld_r    <= 1'b0;
            ovr_r       <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            err_r       <= 1'b0;
            frame_end_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r   <= ST_CAL;
                        busy_r    <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        bit_cnt_r <= {BW{1'b0}};
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end

                ST_CAL: begin
                    if (bc_sync_r) begin
                        cnt_r <= {CNT_W{1'b0}};
                        // A low pulse that is too short is a glitch. It is
                        // dropped without raising an error.
                        if (cnt_r < MIN_HALF) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            half_r  <= cnt_r;
                            state_r <= ST_WAIT_FALL;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        err_r      <= 1'b1;
                        err_code_r <= 2'b11;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_WAIT_FALL: begin
                    if (fall_s) begin
                        state_r <= ST_SAMPLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (cnt_r == TIMEOUT) begin
                        err_r      <= 1'b1;
                        err_code_r <= 2'b10;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_SAMPLE: begin
                    // A fall before the sample point is ignored. The cell
                    // is not resynchronised part way through.
                    if (cnt_r == half_r) begin
                        shreg_r   <= {shreg_r[ID_W-2:0], bc_sync_r};
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        cnt_r     <= {CNT_W{1'b0}};
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            frame_end_r <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT_FALL;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            // When a frame is accepted in the same cycle as an acknowledge,
            // the frame wins. ID_vld stays set and the acknowledge still
            // clears ovr.
            if (frame_end_r && accept_s) begin
                id_r     <= shreg_r;
                id_vld_r <= 1'b1;
                ovr_r    <= clr_ID_vld ? 1'b0 : (ovr_r | id_vld_r);
            end else if (clr_ID_vld) begin
                id_vld_r <= 1'b0;
                ovr_r    <= 1'b0;
            end else begin
                id_vld_r <= id_vld_r;
                ovr_r    <= ovr_r;
            end

            if (frame_end_r && !accept_s) begin
                err_r      <= 1'b1;
                err_code_r <= 2'b01;
            end
        end
    end

    assign ID       = id_r;
    assign ID_vld   = id_vld_r;
    assign ovr      = ovr_r;
    assign err      = err_r;
    assign err_code = err_code_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_barcode_rx.sv
// ---------------------------------------------------------------------------
// tb_barcode_rx
// Directed bench for barcode_rx with ID_W=8, PREFIX_W=2, PREFIX=0,
// MIN_HALF=16 and TIMEOUT=500. The calibration low time is 100 cycles.
// Each data cell lasts 200 cycles: a 1 is low for 50 cycles, a 0 is low
// for 150 cycles, and the DUT samples about 100 cycles after the fall.
// ---------------------------------------------------------------------------
module tb_barcode_rx;

    localparam int T = 100;

    logic       clk;
    logic       rst_n;
    logic       bc;
    logic       clr;
    logic [7:0] id;
    logic       id_vld;
    logic       ovr;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int n_tests;
    int n_fail;
    int err_pulses;
    logic err_prev;
    logic err_long;

    typedef struct {
        logic [7:0] frame;
        logic       exp_vld;
        logic       exp_err;
        logic [1:0] exp_code;
        logic [7:0] exp_id;
    } vec_t;

    vec_t vecs [8];

    barcode_rx #(
        .ID_W(8), .PREFIX_W(2), .PREFIX(0), .CNT_W(22),
        .MIN_HALF(22'd16), .TIMEOUT(22'd500)
    ) dut (
        .clk(clk), .rst_n(rst_n), .BC(bc), .clr_ID_vld(clr),
        .ID(id), .ID_vld(id_vld), .ovr(ovr), .err(err),
        .err_code(err_code), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts err pulses and flags any err that stays high for two cycles.
    always @(negedge clk) begin
        err_prev <= err;
        if (err) err_pulses <= err_pulses + 1;
        if (err && err_prev) err_long <= 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Sends a calibration pulse and then the first nbits cells of f, MSB
    // first. The line is left high at the end.
    task automatic send_cells(input logic [7:0] f, input int nbits);
        bc = 1'b0; wait_cyc(T);
        bc = 1'b1; wait_cyc(T);
        for (int i = 0; i < nbits; i++) begin
            bc = 1'b0;
            wait_cyc(f[7-i] ? T/2 : 3*T/2);
            bc = 1'b1;
            wait_cyc(f[7-i] ? 3*T/2 : T/2);
        end
    endtask

    initial begin
        int e0;
        int k;
        logic hit;
        logic seen_busy;

        n_tests = 0; n_fail = 0;
        err_pulses = 0; err_prev = 1'b0; err_long = 1'b0;
        rst_n = 1'b0; bc = 1'b1; clr = 1'b0;

        //           frame   vld   err   code   id
        vecs[0] = '{8'h2A, 1'b1, 1'b0, 2'b00, 8'h2A};
        vecs[1] = '{8'hC5, 1'b0, 1'b1, 2'b01, 8'h2A};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 2'b01, 8'h11};
        vecs[3] = '{8'h3F, 1'b1, 1'b0, 2'b01, 8'h3F};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 2'b01, 8'h3F};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 2'b01, 8'h00};
        vecs[6] = '{8'h40, 1'b0, 1'b1, 2'b01, 8'h00};
        vecs[7] = '{8'h15, 1'b1, 1'b0, 2'b01, 8'h15};

        // Reset state
        wait_cyc(3);
        check("rst_id", {24'd0, id}, 32'h0);
        check("rst_vld", {31'd0, id_vld}, 32'h0);
        check("rst_ovr", {31'd0, ovr}, 32'h0);
        check("rst_err", {31'd0, err}, 32'h0);
        check("rst_code", {30'd0, err_code}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);
        check("post_rst_busy", {31'd0, busy}, 32'h0);

        // Table-driven frames. Each row is acknowledged before it is sent.
        for (int r = 0; r < 8; r++) begin
            do_clr();
            wait_cyc(2);
            e0 = err_pulses;
            send_cells(vecs[r].frame, 8);
            wait_cyc(5);
            check($sformatf("row%0d_id", r), {24'd0, id}, {24'd0, vecs[r].exp_id});
            check($sformatf("row%0d_vld", r), {31'd0, id_vld}, {31'd0, vecs[r].exp_vld});
            check($sformatf("row%0d_errs", r), err_pulses - e0, {31'd0, vecs[r].exp_err});
            check($sformatf("row%0d_code", r), {30'd0, err_code}, {30'd0, vecs[r].exp_code});
            check($sformatf("row%0d_ovr", r), {31'd0, ovr}, 32'h0);
            check($sformatf("row%0d_busy", r), {31'd0, busy}, 32'h0);
        end

        // Overrun: two good frames arrive without an acknowledge between them.
        do_clr();
        send_cells(8'h11, 8);
        wait_cyc(5);
        check("ovr_first_ovr", {31'd0, ovr}, 32'h0);
        send_cells(8'h22, 8);
        wait_cyc(5);
        check("ovr_id", {24'd0, id}, 32'h22);
        check("ovr_vld", {31'd0, id_vld}, 32'h1);
        check("ovr_ovr", {31'd0, ovr}, 32'h1);
        do_clr();
        wait_cyc(1);
        check("ovr_clr_vld", {31'd0, id_vld}, 32'h0);
        check("ovr_clr_ovr", {31'd0, ovr}, 32'h0);

        // Glitch: a 10-cycle calibration pulse is ignored.
        e0 = err_pulses;
        bc = 1'b0;
        wait_cyc(6);
        check("glitch_busy_hi", {31'd0, busy}, 32'h1);
        wait_cyc(4);
        bc = 1'b1;
        wait_cyc(10);
        check("glitch_busy_lo", {31'd0, busy}, 32'h0);
        check("glitch_errs", err_pulses - e0, 32'h0);
        check("glitch_vld", {31'd0, id_vld}, 32'h0);

        // Timeout: the line stays high after 3 cells. The DUT should abort
        // roughly 400 cycles after the third cell ends.
        send_cells(8'h80, 3);
        hit = 1'b0;
        k = 0;
        while (k < 1000 && !hit) begin
            @(negedge clk);
            k++;
            if (err) hit = 1'b1;
        end
        check("tmo_seen", {31'd0, hit}, 32'h1);
        check("tmo_window", {31'd0, (k >= 380 && k <= 430)}, 32'h1);
        check("tmo_code", {30'd0, err_code}, 32'h2);
        wait_cyc(2);
        check("tmo_busy", {31'd0, busy}, 32'h0);
        check("tmo_id", {24'd0, id}, 32'h22);

        // Acknowledge in the same cycle as frame end. ID_vld was already
        // set, so the frame should win and ovr should be cleared.
        send_cells(8'h05, 8);
        wait_cyc(3);
        check("same_pre_vld", {31'd0, id_vld}, 32'h1);
        hit = 1'b0;
        seen_busy = 1'b0;
        fork
            send_cells(8'h33, 8);
            begin
                for (int j = 0; j < 3000 && !hit; j++) begin
                    @(negedge clk);
                    if (!seen_busy && busy) begin
                        seen_busy = 1'b1;
                    end else if (seen_busy && !busy) begin
                        clr = 1'b1;
                        @(negedge clk);
                        clr = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        wait_cyc(2);
        check("same_hit", {31'd0, hit}, 32'h1);
        check("same_id", {24'd0, id}, 32'h33);
        check("same_vld", {31'd0, id_vld}, 32'h1);
        check("same_ovr", {31'd0, ovr}, 32'h0);

        // Asynchronous reset in the middle of a frame.
        e0 = err_pulses;
        send_cells(8'h2A, 2);
        bc = 1'b0;
        wait_cyc(20);
        check("mid_busy", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_id", {24'd0, id}, 32'h0);
        check("mid_rst_vld", {31'd0, id_vld}, 32'h0);
        check("mid_rst_code", {30'd0, err_code}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        wait_cyc(3);
        bc = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(10);
        check("mid_after_busy", {31'd0, busy}, 32'h0);
        check("mid_after_errs", err_pulses - e0, 32'h0);
        send_cells(8'h2A, 8);
        wait_cyc(5);
        check("recover_id", {24'd0, id}, 32'h2A);
        check("recover_vld", {31'd0, id_vld}, 32'h1);

        check("err_one_cycle", {31'd0, err_long}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
